inst_fetch_mem: RTL and testbench

//  Instruction-side responder for the fetch-address/chip-enable pair driven by the PC register.
//  - Word-organised instruction memory with a configurable number of wait states.
//  - Holds a one-entry "last fetch" latch.
//  - Raises stallreq to the ctrl module until the word for the presented address is valid.
//    The PC register therefore holds pc (stall[0]) for exactly the access latency.
//  - Also provides a write port for program load by bench or boot logic.

---
 rtl/inst_fetch_mem.sv | 111 +++++++++++
 tb/tb_inst_fetch_mem.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
// Instruction memory behind the PC register: wait-stated word reads, a one-entry
// last-fetch latch, and a combinational stall request to the ctrl block.
module inst_fetch_mem #(
  parameter int AW_WORDS    = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stallreq,
  output logic        misalign,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam int DEPTH = 1 << AW_WORDS;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] inst_q, inst_d;
  logic        misalign_q, misalign_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [AW_WORDS-1:0] idx, widx, lat_idx;
  logic hit, same_addr, wr_lat, wr_cur;
  logic unused_wr_bits;

  assign idx     = addr[AW_WORDS+1:2];
  assign widx    = wr_addr[AW_WORDS+1:2];
  assign lat_idx = lat_addr_q[AW_WORDS+1:2];
  assign unused_wr_bits = ^{wr_addr[31:AW_WORDS+2], wr_addr[1:0]};

  assign same_addr  = (addr == lat_addr_q);
  assign hit        = (state_q == DONE) && same_addr && ce;
  assign inst_valid = hit;
  assign stallreq   = ce && !hit;

  // A write landing on the latched word makes the latch (or pending read) stale.
  assign wr_lat = wr_en && (widx == lat_idx) && (state_q == DONE || state_q == WAIT);
  // A write to the word being read on this very edge must beat the read.
  assign wr_cur = wr_en && (widx == idx);

  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (!ce) begin
      state_d = IDLE;
    end else if (wr_lat && same_addr) begin
      state_d = IDLE;
    end else if (hit) begin
      state_d = DONE;
    end else if (state_q == WAIT && same_addr) begin
      if (cnt_q > 4'd1) begin
        cnt_d = cnt_q - 4'd1;
      end else if (wr_cur) begin
        state_d = IDLE;
      end else begin
        inst_d     = mem[idx];
        misalign_d = |lat_addr_q[1:0];
        state_d    = DONE;
      end
    end else begin
      lat_addr_d = addr;
      if (WAIT_STATES == 0) begin
        if (wr_cur) begin
          state_d = IDLE;
        end else begin
          inst_d     = mem[idx];
          misalign_d = |addr[1:0];
          state_d    = DONE;
        end
      end else begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_addr_q <= '0;
      inst_q     <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      inst_q     <= inst_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Memory survives reset; only the write itself is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[widx] <= wr_data;
  end

  assign inst     = inst_q;
  assign misalign = misalign_q;
endmodule

// File: tb/tb_inst_fetch_mem.sv
// Scoreboard bench: three instances (0, 1 and 3 wait states) share one stimulus bus.
module tb_inst_fetch_mem;
  logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, wr_addr = '0, wr_data = '0;
  logic [31:0] inst_w [3];
  logic        vl [3], st [3], ms [3];
  logic [31:0] exp_q [$];
  int n_chk = 0, n_pass = 0;
  int s;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    inst_fetch_mem #(.AW_WORDS(10), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr),
      .inst(inst_w[g]), .inst_valid(vl[g]), .stallreq(st[g]), .misalign(ms[g]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );
  end

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; cyc(); rst = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; cyc(); wr_en = 1'b0;
  endtask

  // Runs until the selected instance reports a hit, then pops the scoreboard.
  task automatic wait_hit(input int sel, input string tag, output int stalls);
    bit got;
    logic [31:0] e;
    stalls = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (vl[sel]) got = 1'b1;
      else begin
        if (st[sel]) stalls++;
        cyc();
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, "_nostall"}, 32'(st[sel]), 32'd0);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      else begin
        e = exp_q.pop_front();
        chk({tag, "_inst"}, inst_w[sel], e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_inst%0d", g), inst_w[g], 32'd0);
      chk($sformatf("rst_mis%0d", g), 32'(ms[g]), 32'd0);
      chk($sformatf("rst_stall%0d", g), 32'(st[g]), 32'd0);
      chk($sformatf("rst_valid%0d", g), 32'(vl[g]), 32'd0);
    end

    // Sequential fetch, pc advancing on the edge ending each hit cycle
    for (int k = 0; k < 4; k++) wr(32'(k * 4), 32'hA000_0000 + 32'(k));
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      addr = '0; ce = 1'b1;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(32'hA000_0000 + 32'(k));
        wait_hit(sel, $sformatf("seq%0d", sel), s);
        chk($sformatf("seq%0d_stalls", sel), 32'(s), 32'(ws_of(sel) + 1));
        cyc(); addr = addr + 32'd4;
      end
      ce = 1'b0; cyc();
    end

    // Held address, three wait states; DONE stays stable
    wr(32'h40, 32'hB000_0016);
    do_reset();
    addr = 32'h40; ce = 1'b1;
    exp_q.push_back(32'hB000_0016);
    wait_hit(2, "ws3", s);
    chk("ws3_stalls", 32'(s), 32'd4);
    chk("ws3_mis", 32'(ms[2]), 32'd0);
    cyc(); #1;
    chk("ws3_hold_valid", 32'(vl[2]), 32'd1);
    chk("ws3_hold_inst", inst_w[2], 32'hB000_0016);
    ce = 1'b0; cyc();

    // Write while in reset is dropped
    rst = 1'b1; wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'hBAD0_BAD0;
    cyc();
    rst = 1'b0; wr_en = 1'b0; addr = 32'h40; ce = 1'b1;
    exp_q.push_back(32'hB000_0016);
    wait_hit(1, "rstwr", s);
    ce = 1'b0; cyc();

    // Branch redirect mid-WAIT
    wr(32'h80, 32'hC000_0032);
    do_reset();
    addr = 32'h40; ce = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1; chk("redir_pre_valid", 32'(vl[2]), 32'd0);
      cyc();
    end
    addr = 32'h80;
    exp_q.push_back(32'hC000_0032);
    wait_hit(2, "redir", s);
    chk("redir_stalls", 32'(s), 32'd4);
    ce = 1'b0; cyc();

    // Write to the latched word invalidates it
    wr(32'h10, 32'h1111_0004);
    do_reset();
    addr = 32'h10; ce = 1'b1;
    exp_q.push_back(32'h1111_0004);
    wait_hit(1, "inv_pre", s);
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEAD_BEEF;
    cyc();
    wr_en = 1'b0;
    #1; chk("inv_stall", 32'(st[1]), 32'd1);
    exp_q.push_back(32'hDEAD_BEEF);
    wait_hit(1, "inv", s);
    chk("inv_stalls", 32'(s), 32'd2);
    ce = 1'b0; cyc();

    // Write and zero-wait completion on the same edge: write wins
    wr(32'h30, 32'hE000_0000);
    do_reset();
    addr = 32'h30; ce = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'hE000_0001;
    cyc();
    wr_en = 1'b0;
    #1; chk("coll_novalid", 32'(vl[0]), 32'd0);
    exp_q.push_back(32'hE000_0001);
    wait_hit(0, "coll", s);
    ce = 1'b0; cyc();

    // Misaligned fetch then aligned fetch
    wr(32'h20, 32'h5000_0008);
    wr(32'h24, 32'h5000_0009);
    do_reset();
    addr = 32'h22; ce = 1'b1;
    exp_q.push_back(32'h5000_0008);
    wait_hit(1, "mis", s);
    chk("mis_flag", 32'(ms[1]), 32'd1);
    cyc(); addr = 32'h24;
    exp_q.push_back(32'h5000_0009);
    wait_hit(1, "al", s);
    chk("al_flag", 32'(ms[1]), 32'd0);
    ce = 1'b0; cyc();

    // Reset mid-WAIT, then ce drop mid-WAIT
    do_reset();
    addr = 32'h40; ce = 1'b1;
    exp_q.push_back(32'hB000_0016);
    wait_hit(2, "pre6", s);
    cyc(); addr = 32'h80;
    cyc(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    #1;
    chk("midrst_inst", inst_w[2], 32'd0);
    chk("midrst_stall", 32'(st[2]), 32'd1);
    chk("midrst_valid", 32'(vl[2]), 32'd0);
    cyc(); cyc();
    ce = 1'b0;
    #1;
    chk("cedrop_stall", 32'(st[2]), 32'd0);
    chk("cedrop_valid", 32'(vl[2]), 32'd0);
    cyc();
    chk("cedrop_stall2", 32'(st[2]), 32'd0);
    ce = 1'b1;
    exp_q.push_back(32'hC000_0032);
    wait_hit(2, "restart", s);
    chk("restart_stalls", 32'(s), 32'd4);
    ce = 1'b0; cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
